// File: rtl/opendap_mem_ap_pkg.sv
// opendap_mem_ap_pkg: MEM-AP register map, CSW fields, encodings and lane helpers.
package opendap_mem_ap_pkg;
    localparam logic [7:0] OFF_CSW  = 8'h00;
    localparam logic [7:0] OFF_TAR  = 8'h04;
    localparam logic [7:0] OFF_DRW  = 8'h0C;
    localparam logic [7:0] OFF_BD0  = 8'h10;
    localparam logic [7:0] OFF_BD1  = 8'h14;
    localparam logic [7:0] OFF_BD2  = 8'h18;
    localparam logic [7:0] OFF_BD3  = 8'h1C;
    localparam logic [7:0] OFF_CFG  = 8'hF4;
    localparam logic [7:0] OFF_BASE = 8'hF8;
    localparam logic [7:0] OFF_IDR  = 8'hFC;

    localparam int CSW_SIZE_LSB = 0;
    localparam int CSW_INC_LSB  = 4;
    localparam int CSW_DEVEN    = 6;
    localparam int CSW_TIP      = 7;
    localparam int CSW_PROT_LSB = 28;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic [1:0] INC_OFF    = 2'b00;
    localparam logic [1:0] INC_SINGLE = 2'b01;

    typedef enum logic [1:0] {XFER_IDLE, XFER_SETUP, XFER_ACCESS} xfer_state_e;

    function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] a);
        return size == SIZE_BYTE ? 4'b0001 << a :
               size == SIZE_HALF ? 4'b0011 << {a[1], 1'b0} : 4'hF;
    endfunction

    function automatic logic [9:0] size_bytes(input logic [2:0] size);
        return size == SIZE_BYTE ? 10'd1 : size == SIZE_HALF ? 10'd2 : 10'd4;
    endfunction
endpackage

// File: rtl/opendap_apb_xfer_fsm.sv
// opendap_apb_xfer_fsm: APB IDLE/SETUP/ACCESS sequencer with abort.
module opendap_apb_xfer_fsm
    import opendap_mem_ap_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic abort_i,
    input  logic pready_i,
    output logic psel_o,
    output logic penable_o,
    output logic idle_o,
    output logic done_o
);
    xfer_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= XFER_IDLE;
        else         state_q <= state_d;
    end

    // Abort wins over a same-cycle pready so the bus result is discarded.
    always_comb begin
        state_d = state_q == XFER_IDLE  ? (start_i ? XFER_SETUP : XFER_IDLE) :
                  abort_i               ? XFER_IDLE :
                  state_q == XFER_SETUP ? XFER_ACCESS :
                  pready_i              ? XFER_IDLE : XFER_ACCESS;
    end

    always_comb begin
        psel_o    = state_q != XFER_IDLE;
        penable_o = state_q == XFER_ACCESS;
        idle_o    = state_q == XFER_IDLE;
        done_o    = state_q == XFER_ACCESS && pready_i && !abort_i;
    end
endmodule

// File: rtl/opendap_mem_ap_apb.sv
// opendap_mem_ap_apb: MEM-AP decoding AP register accesses and issuing DRW/BDx
// accesses as APB4 transfers.
module opendap_mem_ap_apb
    import opendap_mem_ap_pkg::*;
#(
    parameter logic [7:0]  APSEL = 8'h00,
    parameter logic [31:0] IDR   = 32'h0477_0002,
    parameter logic [31:0] BASE  = 32'h0000_0003
) (
    input  logic        swclk,
    input  logic        rst_n,
    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_wen,
    input  logic        ap_ren,
    input  logic        ap_abort,
    output logic [31:0] ap_rdata,
    output logic        ap_rdy,
    output logic        ap_err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    logic [2:0]  size_q, size_d, prot_q, prot_d, pprot_q, pprot_d;
    logic [1:0]  inc_q, inc_d;
    logic [31:0] tar_q, tar_d, rdata_q, rdata_d, paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        err_q, err_d, pwrite_q, pwrite_d, drw_q, drw_d;
    logic [7:0]  off;
    logic [31:0] csw_rd, reg_rd;
    logic        sel_hit, strobe, acc, is_drw, is_bd, bus_go, done;

    assign off     = {ap_addr, 2'b00};
    assign sel_hit = ap_sel == APSEL;
    assign strobe  = (ap_wen | ap_ren) & ap_rdy;
    assign acc     = strobe & sel_hit;
    assign is_drw  = off == OFF_DRW;
    assign is_bd   = off inside {OFF_BD0, OFF_BD1, OFF_BD2, OFF_BD3};
    assign bus_go  = acc & (is_drw | is_bd);

    opendap_apb_xfer_fsm u_fsm (
        .clk_i    (swclk),
        .rst_ni   (rst_n),
        .start_i  (bus_go),
        .abort_i  (ap_abort),
        .pready_i (pready),
        .psel_o   (psel),
        .penable_o(penable),
        .idle_o   (ap_rdy),
        .done_o   (done)
    );

    always_comb begin
        csw_rd = '0;
        csw_rd[CSW_SIZE_LSB +: 3] = size_q;
        csw_rd[CSW_INC_LSB +: 2]  = inc_q;
        csw_rd[CSW_DEVEN]         = 1'b1;
        csw_rd[CSW_TIP]           = !ap_rdy;
        csw_rd[CSW_PROT_LSB +: 3] = prot_q;
        reg_rd = off == OFF_CSW  ? csw_rd :
                 off == OFF_TAR  ? tar_q  :
                 off == OFF_CFG  ? '0     :
                 off == OFF_BASE ? BASE   :
                 off == OFF_IDR  ? IDR    : '0;
    end

    always_comb begin
        size_d   = size_q;
        inc_d    = inc_q;
        prot_d   = prot_q;
        tar_d    = tar_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        drw_d    = drw_q;
        if (acc && ap_wen && off == OFF_CSW) begin
            size_d = ap_wdata[2:0] > SIZE_WORD ? SIZE_WORD : ap_wdata[2:0];
            inc_d  = ap_wdata[5] ? INC_OFF : ap_wdata[5:4];
            prot_d = ap_wdata[30:28];
        end
        if (acc && ap_wen && off == OFF_TAR) tar_d = ap_wdata;
        if (strobe && ap_ren && !bus_go) rdata_d = sel_hit ? reg_rd : '0;
        if (bus_go) begin
            paddr_d  = is_bd ? {tar_q[31:4], ap_addr[1:0], 2'b00} : {tar_q[31:2], 2'b00};
            pwrite_d = ap_wen;
            pwdata_d = ap_wen ? ap_wdata : '0;
            pstrb_d  = !ap_wen ? 4'h0 : is_bd ? 4'hF : lane_strb(size_q, tar_q[1:0]);
            pprot_d  = prot_q;
            drw_d    = is_drw;
        end
        // Only a clean DRW completion advances TAR, wrapping inside the 1KB page.
        if (done) begin
            err_d = pslverr;
            if (!pwrite_q) rdata_d = prdata;
            if (drw_q && !pslverr && inc_q == INC_SINGLE)
                tar_d = {tar_q[31:10], tar_q[9:0] + size_bytes(size_q)};
        end
    end

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            size_q   <= SIZE_WORD;
            inc_q    <= INC_OFF;
            prot_q   <= '0;
            tar_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            drw_q    <= 1'b0;
        end else begin
            size_q   <= size_d;
            inc_q    <= inc_d;
            prot_q   <= prot_d;
            tar_q    <= tar_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
            drw_q    <= drw_d;
        end
    end

    assign ap_rdata = rdata_q;
    assign ap_err   = err_q;
    assign paddr    = paddr_q;
    assign pwrite   = pwrite_q;
    assign pwdata   = pwdata_q;
    assign pstrb    = pstrb_q;
    assign pprot    = pprot_q;
endmodule

// File: tb/tb_opendap_mem_ap_apb.sv
// tb_opendap_mem_ap_apb: directed vectors and hand-written bus sequences for the MEM-AP.
module tb_opendap_mem_ap_apb;
    localparam logic [7:0] APSEL = 8'h00;

    logic        swclk = 1'b0, rst_n = 1'b0;
    logic [7:0]  ap_sel = '0;
    logic [5:0]  ap_addr = '0;
    logic [31:0] ap_wdata = '0, prdata = '0;
    logic        ap_wen = 1'b0, ap_ren = 1'b0, ap_abort = 1'b0, pready = 1'b0, pslverr = 1'b0;
    logic [31:0] ap_rdata, paddr, pwdata;
    logic        ap_rdy, ap_err, psel, penable, pwrite;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    int          n_cmp = 0, n_bad = 0;

    opendap_mem_ap_apb #(.APSEL(APSEL), .IDR(32'h0477_0002), .BASE(32'h0000_0003)) dut (
        .swclk(swclk), .rst_n(rst_n), .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
        .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_abort(ap_abort), .ap_rdata(ap_rdata), .ap_rdy(ap_rdy),
        .ap_err(ap_err), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 swclk = ~swclk;

    typedef struct {
        logic [7:0]  sel;
        logic [5:0]  addr;
        logic        wr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge swclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
        ap_sel = APSEL; ap_addr = a; ap_wdata = d; ap_wen = 1'b1;
        tick();
        ap_wen = 1'b0;
    endtask

    task automatic reg_rd(input string nm, input logic [5:0] a, input logic [31:0] exp);
        ap_sel = APSEL; ap_addr = a; ap_ren = 1'b1;
        tick();
        ap_ren = 1'b0;
        check({nm, " rdata"}, ap_rdata, exp);
    endtask

    // Zero-wait-state transfer: strobe N, SETUP N+1, ACCESS N+2, done N+3.
    task automatic bus_op(input string nm, input logic wr, input logic [5:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb, input logic [2:0] exp_prot,
                          input logic [31:0] rd, input logic err);
        ap_sel = APSEL; ap_addr = a; ap_wdata = wd; ap_wen = wr; ap_ren = !wr;
        tick();
        ap_wen = 1'b0; ap_ren = 1'b0;
        check({nm, " setup psel"}, 32'(psel), 32'd1);
        check({nm, " setup penable"}, 32'(penable), 32'd0);
        check({nm, " setup rdy"}, 32'(ap_rdy), 32'd0);
        check({nm, " paddr"}, paddr, exp_addr);
        check({nm, " pstrb"}, 32'(pstrb), 32'(exp_strb));
        check({nm, " pwrite"}, 32'(pwrite), 32'(wr));
        check({nm, " pprot"}, 32'(pprot), 32'(exp_prot));
        if (wr) check({nm, " pwdata"}, pwdata, wd);
        pready = 1'b1; prdata = rd; pslverr = err;
        tick();
        check({nm, " access penable"}, 32'(penable), 32'd1);
        check({nm, " access rdy"}, 32'(ap_rdy), 32'd0);
        tick();
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        check({nm, " done psel"}, 32'(psel), 32'd0);
        check({nm, " done rdy"}, 32'(ap_rdy), 32'd1);
        check({nm, " done err"}, 32'(ap_err), 32'(err));
        if (!wr) check({nm, " done rdata"}, ap_rdata, rd);
        tick();
        check({nm, " err cleared"}, 32'(ap_err), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 6'h00, 1'b0, 32'h0000_0042};
        vecs[1]  = '{8'h00, 6'h01, 1'b0, 32'h0000_0000};
        vecs[2]  = '{8'h00, 6'h3F, 1'b0, 32'h0477_0002};
        vecs[3]  = '{8'h01, 6'h3F, 1'b0, 32'h0000_0000};
        vecs[4]  = '{8'h00, 6'h3E, 1'b0, 32'h0000_0003};
        vecs[5]  = '{8'h00, 6'h3D, 1'b0, 32'h0000_0000};
        vecs[6]  = '{8'h00, 6'h00, 1'b1, 32'hFFFF_FFFF};
        vecs[7]  = '{8'h00, 6'h00, 1'b0, 32'h7000_0042};
        vecs[8]  = '{8'h00, 6'h01, 1'b1, 32'h1234_5678};
        vecs[9]  = '{8'h01, 6'h01, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{8'h00, 6'h01, 1'b0, 32'h1234_5678};
        vecs[11] = '{8'h00, 6'h00, 1'b1, 32'h0000_0023};
        vecs[12] = '{8'h00, 6'h00, 1'b0, 32'h0000_0042};
        vecs[13] = '{8'h01, 6'h03, 1'b0, 32'h0000_0000};

        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst rdy", 32'(ap_rdy), 32'd1);
        check("rst err", 32'(ap_err), 32'd0);
        check("rst rdata", ap_rdata, 32'd0);
        check("rst psel/penable/pwrite", {29'd0, psel, penable, pwrite}, 32'd0);
        check("rst paddr", paddr, 32'd0);
        check("rst pwdata", pwdata, 32'd0);
        check("rst pstrb/pprot", {25'd0, pstrb, pprot}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            ap_sel = vecs[i].sel; ap_addr = vecs[i].addr; ap_wdata = vecs[i].data;
            ap_wen = vecs[i].wr; ap_ren = !vecs[i].wr;
            check($sformatf("vec%0d strobe rdy", i), 32'(ap_rdy), 32'd1);
            tick();
            ap_wen = 1'b0; ap_ren = 1'b0;
            check($sformatf("vec%0d rdy", i), 32'(ap_rdy), 32'd1);
            check($sformatf("vec%0d psel", i), 32'(psel), 32'd0);
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), ap_rdata, vecs[i].data);
        end

        // Word DRW reads with 1KB TAR wrap.
        reg_wr(6'h00, 32'h0000_0012);
        reg_wr(6'h01, 32'h0000_03FC);
        bus_op("drw rd0", 1'b0, 6'h03, '0, 32'h0000_03FC, 4'h0, 3'd0, 32'hAABB_CCDD, 1'b0);
        reg_rd("tar wrap", 6'h01, 32'h0000_0000);
        bus_op("drw rd1", 1'b0, 6'h03, '0, 32'h0000_0000, 4'h0, 3'd0, 32'h1122_3344, 1'b0);
        reg_rd("tar +4", 6'h01, 32'h0000_0004);

        // Byte then half DRW writes with lane strobes.
        reg_wr(6'h00, 32'h0000_0010);
        reg_wr(6'h01, 32'h0000_1001);
        bus_op("drw wr byte", 1'b1, 6'h03, 32'h0000_5500, 32'h0000_1000, 4'b0010, 3'd0, '0, 1'b0);
        reg_rd("tar +1", 6'h01, 32'h0000_1002);
        reg_wr(6'h00, 32'h0000_0011);
        bus_op("drw wr half", 1'b1, 6'h03, 32'hABCD_0000, 32'h0000_1000, 4'b1100, 3'd0, '0, 1'b0);
        reg_rd("tar +2", 6'h01, 32'h0000_1004);

        // BD2 read with Prot=5, TAR untouched.
        reg_wr(6'h00, 32'h5000_0012);
        reg_wr(6'h01, 32'h2000_0040);
        bus_op("bd2 rd", 1'b0, 6'h06, '0, 32'h2000_0048, 4'h0, 3'd5, 32'hCAFE_F00D, 1'b0);
        reg_rd("tar after bd", 6'h01, 32'h2000_0040);

        // Slave error on a DRW read: no increment.
        reg_wr(6'h00, 32'h0000_0012);
        reg_wr(6'h01, 32'h0000_0200);
        bus_op("drw slverr", 1'b0, 6'h03, '0, 32'h0000_0200, 4'h0, 3'd0, 32'h5A5A_5A5A, 1'b1);
        reg_rd("tar after err", 6'h01, 32'h0000_0200);

        // Stalled write aborted; strobes while busy are ignored.
        reg_wr(6'h01, 32'h0000_0100);
        ap_sel = APSEL; ap_addr = 6'h03; ap_wdata = 32'h0000_00EE; ap_wen = 1'b1;
        tick();
        ap_wen = 1'b0;
        check("abort setup psel", 32'(psel), 32'd1);
        tick();
        check("abort access penable", 32'(penable), 32'd1);
        check("abort tip", 32'(dut.csw_rd[7]), 32'd1);
        ap_addr = 6'h01; ap_wdata = 32'h0000_0BAD; ap_wen = 1'b1;
        tick();
        ap_wen = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort stall psel", 32'(psel), 32'd1);
        check("abort stall rdy", 32'(ap_rdy), 32'd0);
        ap_abort = 1'b1;
        tick();
        ap_abort = 1'b0;
        check("abort psel", 32'(psel), 32'd0);
        check("abort penable", 32'(penable), 32'd0);
        check("abort rdy", 32'(ap_rdy), 32'd1);
        check("abort err", 32'(ap_err), 32'd0);
        reg_rd("tar after abort", 6'h01, 32'h0000_0100);

        // Abort in IDLE does nothing.
        ap_abort = 1'b1;
        tick();
        ap_abort = 1'b0;
        check("idle abort rdy", 32'(ap_rdy), 32'd1);
        reg_rd("tar after idle abort", 6'h01, 32'h0000_0100);

        // Asynchronous reset in SETUP.
        ap_addr = 6'h03; ap_wdata = 32'h1357_9BDF; ap_wen = 1'b1;
        tick();
        ap_wen = 1'b0;
        check("pre-reset psel", 32'(psel), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst psel", 32'(psel), 32'd0);
        check("async rst rdy", 32'(ap_rdy), 32'd1);
        check("async rst paddr", paddr, 32'd0);
        check("async rst pwdata", pwdata, 32'd0);
        check("async rst pwrite/pstrb", {27'd0, pwrite, pstrb}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        reg_rd("tar after rst", 6'h01, 32'h0000_0000);
        reg_rd("csw after rst", 6'h00, 32'h0000_0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
